// File: rtl/axi_stream_strip_header.sv
// Strips a programmable number of leading header bytes from an AXI-Stream packet.
// The payload is re-packed into full MSB-first beats, and the header leaves on a one-cycle side pulse.
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    hdr_valid,
    output logic [DATA_WD-1:0]      hdr_data,
    output logic [DATA_BYTE_WD-1:0] hdr_keep
);
    // Byte counts range over 0..2*DATA_BYTE_WD (residual plus one beat).
    localparam int CW = BYTE_CNT_WD + 2;
    typedef logic [CW-1:0]   cnt_t;
    typedef logic [CW+2:0]   sh_t;
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    function automatic logic [DATA_BYTE_WD-1:0] msb_keep(input cnt_t c);
        logic [DATA_BYTE_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            if (cnt_t'(i) < c) m[DATA_BYTE_WD-1-i] = 1'b1;
        return m;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] lsb_keep(input cnt_t c);
        logic [DATA_BYTE_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            if (cnt_t'(i) < c) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    function automatic cnt_t lead_ones(input logic [DATA_BYTE_WD-1:0] k);
        cnt_t c;
        logic run;
        c   = '0;
        run = 1'b1;
        for (int i = DATA_BYTE_WD - 1; i >= 0; i--) begin
            run = run & k[i];
            if (run) c = c + cnt_t'(1);
        end
        return c;
    endfunction

    state_t                  state_q, state_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    cnt_t                    res_cnt_q, res_cnt_d;
    logic                    valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
    logic                    last_out_q, last_out_d;
    logic                    hdr_valid_q, hdr_valid_d;
    logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
    logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;

    logic                    out_free, acc_in;
    cnt_t                    v, n, h, total, leftover;
    logic [DATA_WD-1:0]      d_m;
    logic [2*DATA_WD-1:0]    cat;
    sh_t                     nsh, hsh, rsh;

    assign out_free = !valid_out_q | ready_out;
    assign ready_in = rst_n & (state_q != FLUSH) & out_free;
    assign acc_in   = valid_in & ready_in;

    always_comb begin
        v   = last_in ? lead_ones(keep_in) : cnt_t'(DATA_BYTE_WD);
        d_m = data_in & lane_mask(msb_keep(v));
        n   = (cnt_t'(byte_strip_cnt) > cnt_t'(DATA_BYTE_WD)) ? cnt_t'(DATA_BYTE_WD)
                                                             : cnt_t'(byte_strip_cnt);
        h   = (n < v) ? n : v;
        nsh = {n, 3'b000};
        hsh = {cnt_t'(cnt_t'(DATA_BYTE_WD) - h), 3'b000};
        rsh = {res_cnt_q, 3'b000};
        // Residual sits MSB-first; the new beat is appended directly behind it.
        cat      = {res_q, {DATA_WD{1'b0}}} | ({d_m, {DATA_WD{1'b0}}} >> rsh);
        total    = res_cnt_q + v;
        leftover = total - cnt_t'(DATA_BYTE_WD);
    end

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        res_cnt_d   = res_cnt_q;
        valid_out_d = valid_out_q & !ready_out;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        hdr_valid_d = 1'b0;
        hdr_data_d  = '0;
        hdr_keep_d  = '0;
        case (state_q)
            IDLE: if (acc_in) begin
                hdr_valid_d = (n != '0);
                hdr_data_d  = d_m >> hsh;
                hdr_keep_d  = lsb_keep(h);
                res_d       = d_m << nsh;
                res_cnt_d   = (v > n) ? cnt_t'(v - n) : '0;
                if (!last_in)          state_d = STREAM;
                else if (v > n)        state_d = FLUSH;
                else                   state_d = IDLE;
            end
            STREAM: if (acc_in) begin
                valid_out_d = 1'b1;
                data_out_d  = cat[2*DATA_WD-1:DATA_WD];
                if (total >= cnt_t'(DATA_BYTE_WD)) begin
                    keep_out_d = '1;
                    res_d      = cat[DATA_WD-1:0];
                    res_cnt_d  = leftover;
                    last_out_d = last_in & (leftover == '0);
                    if (last_in) state_d = (leftover == '0) ? IDLE : FLUSH;
                end else begin
                    keep_out_d = msb_keep(total);
                    last_out_d = 1'b1;
                    res_d      = '0;
                    res_cnt_d  = '0;
                    state_d    = IDLE;
                end
            end
            FLUSH: if (out_free) begin
                valid_out_d = 1'b1;
                data_out_d  = res_q;
                keep_out_d  = msb_keep(res_cnt_q);
                last_out_d  = 1'b1;
                res_d       = '0;
                res_cnt_d   = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            res_q       <= '0;
            res_cnt_q   <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
            hdr_valid_q <= 1'b0;
            hdr_data_q  <= '0;
            hdr_keep_q  <= '0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            res_cnt_q   <= res_cnt_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_data_q  <= hdr_data_d;
            hdr_keep_q  <= hdr_keep_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign keep_out  = keep_out_q;
    assign last_out  = last_out_q;
    assign hdr_valid = hdr_valid_q;
    assign hdr_data  = hdr_data_q;
    assign hdr_keep  = hdr_keep_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Cycle-by-cycle directed vectors for axi_stream_strip_header, plus backpressure and reset-in-FLUSH sequences.
module tb_axi_stream_strip_header;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, last_in, ready_in, ready_out;
    logic [31:0] data_in, data_out, hdr_data;
    logic [3:0]  keep_in, keep_out, hdr_keep;
    logic [2:0]  byte_strip_cnt;
    logic        valid_out, last_out, hdr_valid;

    int n_chk  = 0;
    int n_fail = 0;

    axi_stream_strip_header #(.DATA_WD(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in), .byte_strip_cnt(byte_strip_cnt),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out),
        .hdr_valid(hdr_valid), .hdr_data(hdr_data), .hdr_keep(hdr_keep)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vi; logic [31:0] di; logic [3:0] ki; logic li; logic [2:0] cnt; logic ro;
        logic        e_rdy; logic e_vo; logic [31:0] e_do; logic [3:0] e_ko; logic e_lo;
        logic        e_hv; logic [31:0] e_hd; logic [3:0] e_hk;
    } vec_t;

    function automatic vec_t mk(input logic vi, input logic [31:0] di, input logic [3:0] ki,
                                input logic li, input logic [2:0] cnt, input logic ro,
                                input logic e_rdy, input logic e_vo, input logic [31:0] e_do,
                                input logic [3:0] e_ko, input logic e_lo, input logic e_hv,
                                input logic [31:0] e_hd, input logic [3:0] e_hk);
        vec_t r;
        r.vi = vi; r.di = di; r.ki = ki; r.li = li; r.cnt = cnt; r.ro = ro;
        r.e_rdy = e_rdy; r.e_vo = e_vo; r.e_do = e_do; r.e_ko = e_ko; r.e_lo = e_lo;
        r.e_hv = e_hv; r.e_hd = e_hd; r.e_hk = e_hk;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    // Called at a negedge: drive inputs, check outputs, advance to the next negedge.
    task automatic step(input vec_t t, input int idx);
        valid_in = t.vi; data_in = t.di; keep_in = t.ki; last_in = t.li;
        byte_strip_cnt = t.cnt; ready_out = t.ro;
        #1;
        chk("ready_in",  idx, {31'b0, ready_in},  {31'b0, t.e_rdy});
        chk("valid_out", idx, {31'b0, valid_out}, {31'b0, t.e_vo});
        chk("hdr_valid", idx, {31'b0, hdr_valid}, {31'b0, t.e_hv});
        if (t.e_vo) begin
            chk("data_out", idx, data_out, t.e_do);
            chk("keep_out", idx, {28'b0, keep_out}, {28'b0, t.e_ko});
            chk("last_out", idx, {31'b0, last_out}, {31'b0, t.e_lo});
        end
        if (t.e_hv) begin
            chk("hdr_data", idx, hdr_data, t.e_hd);
            chk("hdr_keep", idx, {28'b0, hdr_keep}, {28'b0, t.e_hk});
        end
        @(negedge clk);
    endtask

    task automatic chk_zero(input int idx);
        chk("rst ready_in",  idx, {31'b0, ready_in},  32'd0);
        chk("rst valid_out", idx, {31'b0, valid_out}, 32'd0);
        chk("rst data_out",  idx, data_out,           32'd0);
        chk("rst keep_out",  idx, {28'b0, keep_out},  32'd0);
        chk("rst last_out",  idx, {31'b0, last_out},  32'd0);
        chk("rst hdr_valid", idx, {31'b0, hdr_valid}, 32'd0);
        chk("rst hdr_data",  idx, hdr_data,           32'd0);
        chk("rst hdr_keep",  idx, {28'b0, hdr_keep},  32'd0);
    endtask

    vec_t tv[14];
    vec_t bp[8];

    initial begin
        // vi  data          keep  last cnt ro | rdy vo data_out      keep lo | hv hdr_data      hkeep
        tv[0]  = mk(1, 32'hAABBCCDD, 4'hF, 0, 1, 1,  1, 0, 32'h0,        4'h0, 0,  0, 32'h0,        4'h0);
        tv[1]  = mk(1, 32'h11223344, 4'hF, 1, 2, 1,  1, 0, 32'h0,        4'h0, 0,  1, 32'h000000AA, 4'h1);
        tv[2]  = mk(0, 32'h0,        4'h0, 0, 1, 1,  0, 1, 32'hBBCCDD11, 4'hF, 0,  0, 32'h0,        4'h0);
        tv[3]  = mk(0, 32'h0,        4'h0, 0, 1, 1,  1, 1, 32'h22334400, 4'hE, 1,  0, 32'h0,        4'h0);
        tv[4]  = mk(0, 32'h0,        4'h0, 0, 1, 1,  1, 0, 32'h0,        4'h0, 0,  0, 32'h0,        4'h0);
        tv[5]  = mk(1, 32'hAABBCCDD, 4'hF, 0, 2, 1,  1, 0, 32'h0,        4'h0, 0,  0, 32'h0,        4'h0);
        tv[6]  = mk(1, 32'h11225566, 4'hC, 1, 2, 1,  1, 0, 32'h0,        4'h0, 0,  1, 32'h0000AABB, 4'h3);
        tv[7]  = mk(0, 32'h0,        4'h0, 0, 2, 1,  1, 1, 32'hCCDD1122, 4'hF, 1,  0, 32'h0,        4'h0);
        tv[8]  = mk(1, 32'hAABBCCDD, 4'hF, 1, 4, 1,  1, 0, 32'h0,        4'h0, 0,  0, 32'h0,        4'h0);
        tv[9]  = mk(1, 32'h01020304, 4'hF, 0, 0, 1,  1, 0, 32'h0,        4'h0, 0,  1, 32'hAABBCCDD, 4'hF);
        tv[10] = mk(1, 32'h05060708, 4'h8, 1, 3, 1,  1, 0, 32'h0,        4'h0, 0,  0, 32'h0,        4'h0);
        tv[11] = mk(0, 32'h0,        4'h0, 0, 0, 1,  0, 1, 32'h01020304, 4'hF, 0,  0, 32'h0,        4'h0);
        tv[12] = mk(0, 32'h0,        4'h0, 0, 0, 1,  1, 1, 32'h05000000, 4'h8, 1,  0, 32'h0,        4'h0);
        tv[13] = mk(0, 32'h0,        4'h0, 0, 0, 1,  1, 0, 32'h0,        4'h0, 0,  0, 32'h0,        4'h0);

        // Scenario 1 with the first output beat stalled for three cycles.
        bp[0] = tv[0];
        bp[1] = tv[1];
        bp[2] = mk(0, 32'h0, 4'h0, 0, 1, 0,  0, 1, 32'hBBCCDD11, 4'hF, 0,  0, 32'h0, 4'h0);
        bp[3] = bp[2];
        bp[4] = bp[2];
        bp[5] = mk(0, 32'h0, 4'h0, 0, 1, 1,  0, 1, 32'hBBCCDD11, 4'hF, 0,  0, 32'h0, 4'h0);
        bp[6] = tv[3];
        bp[7] = tv[4];

        rst_n = 1'b0; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        byte_strip_cnt = '0; ready_out = 1'b1;
        @(negedge clk);
        chk_zero(100);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) step(tv[i], i);
        for (int i = 0; i < 8; i++) step(bp[i], 200 + i);

        // Reset asserted while the residual beat is waiting in FLUSH.
        step(tv[0], 300);
        step(tv[1], 301);
        valid_in = 1'b0;
        ready_out = 1'b0;
        #1;
        chk("pre-rst valid_out", 302, {31'b0, valid_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero(303);
        @(negedge clk);
        chk_zero(304);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(tv[i], 310 + i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
